// File: rtl/ras_pkg.sv
// Shared types and defaults for the return-address stack.
package ras_pkg;

  localparam int unsigned DEPTH_DEF = 16;
  localparam int unsigned WIDTH_DEF = 32;
  // Checkpoint fields are sized for the largest supported stack depth.
  localparam int unsigned PTR_MAX_W = 16;

  typedef logic [PTR_MAX_W-1:0] ptr_t;
  typedef logic [PTR_MAX_W:0]   cnt_t;

  typedef struct packed {
    ptr_t ptr;
    cnt_t count;
  } ckpt_t;

endpackage

// File: rtl/bram.sv
// Dual-port synchronous RAM with read-first behaviour on each port.
// OFS rotates both port addresses; INCR adds extra read-register stages.
module bram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OFS   = 0,
  parameter int unsigned INCR  = 0
) (
  input  logic                     clk,
  input  logic                     a_we,
  input  logic                     a_re,
  input  logic [$clog2(DEPTH)-1:0] a_addr,
  input  logic [WIDTH-1:0]         a_wdata,
  output logic [WIDTH-1:0]         a_rdata,
  input  logic                     b_we,
  input  logic                     b_re,
  input  logic [$clog2(DEPTH)-1:0] b_addr,
  input  logic [WIDTH-1:0]         b_wdata,
  output logic [WIDTH-1:0]         b_rdata
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    a_idx;
  logic [AW-1:0]    b_idx;
  logic [WIDTH-1:0] a_rd_q;
  logic [WIDTH-1:0] b_rd_q;

  assign a_idx = a_addr + AW'(OFS);
  assign b_idx = b_addr + AW'(OFS);

  // Port A write lands after port B on a same-address collision.
  always_ff @(posedge clk) begin
    if (b_we) mem_q[b_idx] <= b_wdata;
    if (a_we) mem_q[a_idx] <= a_wdata;
    if (a_re) a_rd_q <= mem_q[a_idx];
    if (b_re) b_rd_q <= mem_q[b_idx];
  end

  generate
    if (INCR == 0) begin : g_direct
      assign a_rdata = a_rd_q;
      assign b_rdata = b_rd_q;
    end else begin : g_pipe
      logic [WIDTH-1:0] a_pipe_q [INCR];
      logic [WIDTH-1:0] b_pipe_q [INCR];

      always_ff @(posedge clk) begin
        a_pipe_q[0] <= a_rd_q;
        b_pipe_q[0] <= b_rd_q;
        for (int unsigned i = 1; i < INCR; i++) begin
          a_pipe_q[i] <= a_pipe_q[i-1];
          b_pipe_q[i] <= b_pipe_q[i-1];
        end
      end

      assign a_rdata = a_pipe_q[INCR-1];
      assign b_rdata = b_pipe_q[INCR-1];
    end
  endgenerate

endmodule

// File: rtl/ras_stack.sv
// Return-address stack: circular storage that overwrites the oldest entry when full.
// Optional checkpoint/restore of ptr and count with macro RAS_CKPT_EN.
module ras_stack
  import ras_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef RAS_CKPT_EN
  input  logic                   ckpt,
  input  logic                   restore,
`endif
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic                   pop_valid,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   pop_underflow,
  output logic                   push_overflow,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_valid_q, pop_valid_d;
  logic             pop_uf_q, pop_uf_d;
  logic             push_ovf_q, push_ovf_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;

  logic [PW-1:0]    top_c;
  logic             is_empty_c;
  logic             is_full_c;
  logic             restore_c;
  logic             wr_en;
  logic [PW-1:0]    wr_addr;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] a_rdata_unused;

`ifdef RAS_CKPT_EN
  ckpt_t ckpt_q, ckpt_d;
  assign restore_c = restore;
`else
  assign restore_c = 1'b0;
`endif

  assign top_c      = ptr_q - PW'(1);
  assign is_empty_c = (count_q == CW'(0));
  assign is_full_c  = (count_q == CW'(DEPTH));

  // Next-state: restore beats push/pop; push+pop on a non-empty stack replaces the top.
  always_comb begin
    ptr_d       = ptr_q;
    count_d     = count_q;
    pop_valid_d = 1'b0;
    pop_uf_d    = 1'b0;
    push_ovf_d  = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = ptr_q;
    rd_en       = 1'b0;
`ifdef RAS_CKPT_EN
    ckpt_d      = ckpt_q;
`endif
    if (!rst) begin
      if (restore_c) begin
`ifdef RAS_CKPT_EN
        ptr_d   = PW'(ckpt_q.ptr);
        count_d = CW'(ckpt_q.count);
`endif
      end else if (push && pop && !is_empty_c) begin
        wr_en       = 1'b1;
        wr_addr     = top_c;
        rd_en       = 1'b1;
        pop_valid_d = 1'b1;
      end else begin
        if (push) begin
          wr_en      = 1'b1;
          ptr_d      = ptr_q + PW'(1);
          count_d    = is_full_c ? count_q : count_q + CW'(1);
          push_ovf_d = is_full_c;
        end
        if (pop) begin
          pop_valid_d = 1'b1;
          if (is_empty_c) begin
            pop_uf_d = 1'b1;
          end else begin
            rd_en   = 1'b1;
            ptr_d   = top_c;
            count_d = count_q - CW'(1);
          end
        end
      end
`ifdef RAS_CKPT_EN
      if (ckpt && !restore_c) begin
        ckpt_d = '{ptr: PTR_MAX_W'(ptr_q), count: (PTR_MAX_W + 1)'(count_q)};
      end
`endif
    end
    empty_d = (count_d == CW'(0));
    full_d  = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      count_q     <= '0;
      pop_valid_q <= 1'b0;
      pop_uf_q    <= 1'b0;
      push_ovf_q  <= 1'b0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
`ifdef RAS_CKPT_EN
      ckpt_q      <= '0;
`endif
    end else begin
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      pop_valid_q <= pop_valid_d;
      pop_uf_q    <= pop_uf_d;
      push_ovf_q  <= push_ovf_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
`ifdef RAS_CKPT_EN
      ckpt_q      <= ckpt_d;
`endif
    end
  end

  // A result pending while reset is asserted is dropped immediately.
  assign pop_valid     = pop_valid_q & ~rst;
  assign pop_underflow = pop_uf_q & ~rst;
  assign pop_data      = (pop_valid && !pop_uf_q) ? rd_data : WIDTH'(0);
  assign push_overflow = push_ovf_q;
  assign empty         = empty_q;
  assign full          = full_q;
  assign count         = count_q;

  bram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .OFS   (0),
    .INCR  (0)
  ) u_bram (
    .clk     (clk),
    .a_we    (wr_en),
    .a_re    (1'b0),
    .a_addr  (wr_addr),
    .a_wdata (push_data),
    .a_rdata (a_rdata_unused),
    .b_we    (1'b0),
    .b_re    (rd_en),
    .b_addr  (top_c),
    .b_wdata (WIDTH'(0)),
    .b_rdata (rd_data)
  );

endmodule

// File: tb/tb_ras_stack.sv
// Scoreboard bench for ras_stack: driver queues expected pop results, monitor checks them.
// Checkpoint scenario is built when RAS_CKPT_EN is defined.
module tb_ras_stack;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned WIDTH = 32;

  typedef struct {
    logic             uf;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic                   clk;
  logic                   rst;
  logic                   ckpt;
  logic                   restore;
  logic                   push;
  logic [WIDTH-1:0]       push_data;
  logic                   pop;
  logic                   pop_valid;
  logic [WIDTH-1:0]       pop_data;
  logic                   pop_underflow;
  logic                   push_overflow;
  logic                   empty;
  logic                   full;
  logic [$clog2(DEPTH):0] count;

  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  ras_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst           (rst),
`ifdef RAS_CKPT_EN
    .ckpt          (ckpt),
    .restore       (restore),
`endif
    .push          (push),
    .push_data     (push_data),
    .pop           (pop),
    .pop_valid     (pop_valid),
    .pop_data      (pop_data),
    .pop_underflow (pop_underflow),
    .push_overflow (push_overflow),
    .empty         (empty),
    .full          (full),
    .count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: compare each presented pop result against the oldest expectation.
  always @(negedge clk) begin
    if (pop_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pop: got data 0x%0h uf %0b, expected no result", pop_data, pop_underflow);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pop_data", pop_data, e.data);
        check("pop_underflow", 32'(pop_underflow), 32'(e.uf));
      end
    end else begin
      check("pop_data_idle", pop_data, 32'h0);
    end
  end

  task automatic cyc(input logic p, input logic [WIDTH-1:0] d, input logic q);
    push      = p;
    push_data = d;
    pop       = q;
    @(posedge clk);
    #1;
    push      = 1'b0;
    push_data = '0;
    pop       = 1'b0;
    ckpt      = 1'b0;
    restore   = 1'b0;
  endtask

  task automatic expect_pop(input logic [WIDTH-1:0] d, input logic uf);
    exp_t e;
    e.data = d;
    e.uf   = uf;
    exp_q.push_back(e);
  endtask

  task automatic do_pop(input logic [WIDTH-1:0] d, input logic uf);
    expect_pop(d, uf);
    cyc(1'b0, '0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; ckpt = 1'b0; restore = 1'b0;
    push = 1'b0; push_data = '0; pop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pop_valid", 32'(pop_valid), 32'h0);
    rst = 1'b0;
    check("rst_empty", 32'(empty), 32'h1);
    check("rst_count", 32'(count), 32'h0);
    check("rst_full", 32'(full), 32'h0);

    // Basic LIFO order, pop right after push, back-to-back pops.
    cyc(1'b1, 32'h100, 1'b0);
    cyc(1'b1, 32'h200, 1'b0);
    check("two_push_count", 32'(count), 32'h2);
    check("two_push_empty", 32'(empty), 32'h0);
    do_pop(32'h200, 1'b0);
    do_pop(32'h100, 1'b0);
    check("drain_count", 32'(count), 32'h0);
    check("drain_empty", 32'(empty), 32'h1);

    // Underflow.
    do_pop(32'h0, 1'b1);
    check("uf_count", 32'(count), 32'h0);
    check("uf_empty", 32'(empty), 32'h1);
    cyc(1'b0, '0, 1'b0);

    // Overflow wraps and overwrites the oldest entry.
    for (int i = 1; i <= 17; i++) begin
      cyc(1'b1, WIDTH'(i), 1'b0);
      check($sformatf("ovf_pulse_%0d", i), 32'(push_overflow), (i == 17) ? 32'h1 : 32'h0);
    end
    check("ovf_full", 32'(full), 32'h1);
    check("ovf_count", 32'(count), 32'd16);
    cyc(1'b0, '0, 1'b0);
    check("ovf_pulse_end", 32'(push_overflow), 32'h0);
    for (int k = 17; k >= 2; k--) do_pop(WIDTH'(k), 1'b0);
    check("ovf_drain_empty", 32'(empty), 32'h1);
    do_pop(32'h0, 1'b1);
    cyc(1'b0, '0, 1'b0);

    // Replace the top with simultaneous push and pop.
    cyc(1'b1, 32'hA, 1'b0);
    expect_pop(32'hA, 1'b0);
    cyc(1'b1, 32'hB, 1'b1);
    check("replace_count", 32'(count), 32'h1);
    do_pop(32'hB, 1'b0);
    check("replace_drain", 32'(count), 32'h0);

    // Push and pop together on an empty stack.
    expect_pop(32'h0, 1'b1);
    cyc(1'b1, 32'h55, 1'b1);
    check("pp_empty_count", 32'(count), 32'h1);
    do_pop(32'h55, 1'b0);
    cyc(1'b0, '0, 1'b0);

`ifdef RAS_CKPT_EN
    // Checkpoint, speculative push/pops, then restore (which also cancels its pop).
    cyc(1'b1, 32'h1, 1'b0);
    cyc(1'b1, 32'h2, 1'b0);
    ckpt = 1'b1;
    cyc(1'b0, '0, 1'b0);
    cyc(1'b1, 32'h3, 1'b0);
    do_pop(32'h3, 1'b0);
    do_pop(32'h2, 1'b0);
    check("pre_restore_count", 32'(count), 32'h1);
    restore = 1'b1;
    ckpt    = 1'b1;
    cyc(1'b1, 32'hDEAD, 1'b1);
    check("restore_count", 32'(count), 32'h2);
    do_pop(32'h2, 1'b0);
    do_pop(32'h1, 1'b0);
    check("ckpt_drain", 32'(count), 32'h0);
    cyc(1'b0, '0, 1'b0);
`endif

    // Reset in the cycle after a pop drops the pending result.
    cyc(1'b1, 32'h77, 1'b0);
    cyc(1'b1, 32'h88, 1'b0);
    cyc(1'b0, '0, 1'b1);
    rst = 1'b1;
    push = 1'b1; push_data = 32'h99; pop = 1'b1;
    #1;
    check("mid_rst_pop_valid", 32'(pop_valid), 32'h0);
    check("mid_rst_pop_data", pop_data, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0; push = 1'b0; push_data = '0; pop = 1'b0;
    check("post_rst_count", 32'(count), 32'h0);
    check("post_rst_empty", 32'(empty), 32'h1);
    check("post_rst_pop_valid", 32'(pop_valid), 32'h0);
    check("post_rst_ovf", 32'(push_overflow), 32'h0);
    do_pop(32'h0, 1'b1);

    repeat (3) cyc(1'b0, '0, 1'b0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
